// File: rtl/priority_decoder.sv
// Highest-index-wins priority encoder with a zero-latency path and a one-cycle registered copy.
// Optional macro PRIORITY_DECODER_ONEHOT_EN adds the one-hot winner output `onehot`.
module priority_decoder #(
  parameter  int WIDTH     = 4,
  localparam int OUT_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic                 valid_q
`ifdef PRIORITY_DECODER_ONEHOT_EN
  ,
  output logic [WIDTH-1:0]     onehot
`endif
);

  logic [OUT_WIDTH-1:0] w_out;
  logic                 w_valid;
  logic [OUT_WIDTH-1:0] r_out_q;
  logic                 r_valid_q;

  // Upward scan: a later (higher) set bit overwrites any lower winner, so out stays 0 when in is 0.
  always_comb begin
    w_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        w_out = OUT_WIDTH'(i);
      end else begin
        w_out = w_out;
      end
    end
  end

  assign w_valid = |in;
  assign out     = w_out;
  assign valid   = w_valid;

  // One-cycle registered copy of the combinational result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_out_q   <= w_out;
      r_valid_q <= w_valid;
    end
  end

  assign out_q   = r_out_q;
  assign valid_q = r_valid_q;

`ifdef PRIORITY_DECODER_ONEHOT_EN
  logic [WIDTH-1:0] w_onehot;

  // Keep only the winning bit; all zero when no request is present.
  always_comb begin
    w_onehot = '0;
    if (w_valid) begin
      w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << w_out;
    end else begin
      w_onehot = '0;
    end
  end

  assign onehot = w_onehot;
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: WIDTH=4 and WIDTH=5 instances driven side by side.
module tb_priority_decoder;

  typedef struct packed {
    logic [1:0] o4;
    logic       v4;
    logic [2:0] o5;
    logic       v5;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] in4;
  logic [4:0] in5;
  logic [1:0] out4, out_q4;
  logic       valid4, valid_q4;
  logic [2:0] out5, out_q5;
  logic       valid5, valid_q5;
`ifdef PRIORITY_DECODER_ONEHOT_EN
  logic [3:0] onehot4;
  logic [4:0] onehot5;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t comb_q[$];
  exp_t reg_q[$];

  priority_decoder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .out(out4), .valid(valid4),
    .out_q(out_q4), .valid_q(valid_q4)
`ifdef PRIORITY_DECODER_ONEHOT_EN
    , .onehot(onehot4)
`endif
  );

  priority_decoder #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in(in5), .out(out5), .valid(valid5),
    .out_q(out_q5), .valid_q(valid_q5)
`ifdef PRIORITY_DECODER_ONEHOT_EN
    , .onehot(onehot5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int o4, input int v4, input int o5, input int v5);
    exp_t e;
    e.o4 = 2'(o4);
    e.v4 = 1'(v4);
    e.o5 = 3'(o5);
    e.v5 = 1'(v5);
    return e;
  endfunction

  // Reference model: scan downward from the top bit, first hit wins.
  function automatic int ref_idx(input logic [4:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic drive(input logic [3:0] v4, input logic [4:0] v5, input exp_t e);
    @(negedge clk);
    in4 = v4;
    in5 = v5;
    comb_q.push_back(e);
    if (rst_n) reg_q.push_back(e);
  endtask

  // Combinational monitor: checks shortly after each new vector settles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        chk("out4", 64'(out4), 64'(e.o4));
        chk("valid4", 64'(valid4), 64'(e.v4));
        chk("out5", 64'(out5), 64'(e.o5));
        chk("valid5", 64'(valid5), 64'(e.v5));
`ifdef PRIORITY_DECODER_ONEHOT_EN
        chk("onehot4", 64'(onehot4), e.v4 ? (64'd1 << e.o4) : 64'd0);
        chk("onehot5", 64'(onehot5), e.v5 ? (64'd1 << e.o5) : 64'd0);
`endif
      end
    end
  end

  // Registered monitor: checks one step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        chk("out_q4", 64'(out_q4), 64'(e.o4));
        chk("valid_q4", 64'(valid_q4), 64'(e.v4));
        chk("out_q5", 64'(out_q5), 64'(e.o5));
        chk("valid_q5", 64'(valid_q5), 64'(e.v5));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   r4, r5;
    logic [4:0] vv;
    rst_n = 1'b0;
    in4   = 4'b0000;
    in5   = 5'b00000;
    #1;
    chk("rst_out_q4", 64'(out_q4), 64'd0);
    chk("rst_valid_q4", 64'(valid_q4), 64'd0);
    chk("rst_valid5", 64'(valid5), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid_q4", 64'(valid_q4), 64'd0);
    rst_n = 1'b1;

    drive(4'b0000, 5'b00000, mk(0, 0, 0, 0));
    drive(4'b0001, 5'b00001, mk(0, 1, 0, 1));
    drive(4'b0100, 5'b10000, mk(2, 1, 4, 1));
    drive(4'b1111, 5'b11111, mk(3, 1, 4, 1));
    drive(4'b1000, 5'b01000, mk(3, 1, 3, 1));

    // Mid-cycle asynchronous reset after capturing 0110.
    e = mk(2, 1, 2, 1);
    drive(4'b0110, 5'b00110, e);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_q4", 64'(out_q4), 64'd0);
    chk("async_valid_q4", 64'(valid_q4), 64'd0);
    chk("async_out_q5", 64'(out_q5), 64'd0);
    chk("async_out4", 64'(out4), 64'd2);
    chk("async_valid4", 64'(valid4), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    reg_q.push_back(e);

    // Return to idle: valid falls immediately, valid_q only after the next edge.
    drive(4'b1111, 5'b11111, mk(3, 1, 4, 1));
    drive(4'b0000, 5'b00000, mk(0, 0, 0, 0));
    #1;
    chk("ret_valid4", 64'(valid4), 64'd0);
    chk("ret_valid_q4_held", 64'(valid_q4), 64'd1);

    // Exhaustive sweep of all 5-bit inputs (low 4 bits feed the WIDTH=4 instance).
    for (int v = 0; v < 32; v++) begin
      vv = 5'(v);
      r4 = ref_idx(vv & 5'b01111, 4);
      r5 = ref_idx(vv, 5);
      drive(vv[3:0], vv, mk(r4, int'(|vv[3:0]), r5, int'(|vv)));
    end

    repeat (3) @(negedge clk);
    chk("comb_q_drained", 64'(comb_q.size()), 64'd0);
    chk("reg_q_drained", 64'(reg_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
